as65x_bus_arbiter: RTL and testbench
====================================

// Module: as65x_bus_arbiter
// PURPOSE
//  Shares the as65x CPU bus (A/D/RWn) with one DMA requester (video/refresh/blitter) by cycle stealing.
//  Halts the CPU with RDY, waits out pending write cycles, then floats the CPU bus with AEC and grants it to DMA.
//  Sits between the pad ring and the cpu65 RDY/AEC inputs; one bus cycle per clk_i cycle.
// PARAMETERS
//  RDY_LEAD   3   cycles RDY is held low before AEC drops (covers max 3 consecutive 65xx writes)
//  MAX_BURST  40  max consecutive granted cycles (used only with AS65X_ARB_FAIR_EN)
//  CNT_W      16  width of stolen-cycle counter
// PORTS
//  clk_i          in   1      CPU phase clock (PH0IN domain), all logic on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  cpu_rwn        in   1      CPU RWn of current cycle (1=read)
//  cpu_rdy_writes in   1      1: CPU halts on write cycles too (rdy_writes strap)
//  dma_req        in   1      DMA requests bus; level, held until done
//  dma_grant      out  1      DMA owns address/data/RWn this cycle
//  cpu_rdy        out  1      to cpu65 RDY (0=halt)
//  cpu_aec        out  1      to cpu65 AEC (0=CPU bus outputs tristated)
//  arb_busy       out  1      state != IDLE
//  steal_cnt      out  CNT_W  number of granted cycles since reset, saturating
//  steal_clr      in   1      synchronous clear of steal_cnt
// BEHAVIOUR
//  All outputs registered. Reset: IDLE, cpu_rdy=1, cpu_aec=1, dma_grant=0, arb_busy=0, steal_cnt=0.
//  States (2-bit encoded): IDLE, HALT, GRANT, RELEASE.
//  IDLE: rdy=1, aec=1, grant=0. dma_req=1 -> HALT, lead_cnt<=0.
//  HALT: rdy=0, aec=1, grant=0. lead_cnt increments each cycle.
//   - dma_req=0 -> IDLE (abort; no grant issued, rdy=1 next cycle).
//   - cpu_rdy_writes=1 and cpu_rwn=1 -> GRANT (CPU already stopped; early exit).
//   - lead_cnt==RDY_LEAD-1 -> GRANT regardless of cpu_rwn.
//   - abort has priority over both exits.
//  GRANT: rdy=0, aec=0, grant=1. burst_cnt increments; steal_cnt+1 each cycle (saturate at all-ones).
//   - dma_req=0 -> RELEASE; the cycle in which dma_req is sampled 0 is still a grant cycle.
//  RELEASE: rdy=0, aec=1, grant=0 (one bus-turnaround cycle) -> IDLE unconditionally.
//  CPU resumes: >=1 IDLE cycle with rdy=1 always follows RELEASE; req re-evaluated from IDLE.
//  Latency: req asserted at edge N -> grant=1 at N+1+RDY_LEAD (worst case), N+2 (early exit).
//  Simultaneous steal_clr and grant: clear wins, counter reads 0 (the grant cycle is not counted).
//  Never grant=1 with aec=1; never aec=0 with rdy=1 (checked by assertions).
//  Reset mid-GRANT: outputs return to reset values asynchronously; DMA must tolerate loss of grant.
// CONFIGURATION
//  AS65X_ARB_FAIR_EN defined: burst_cnt reaching MAX_BURST-1 in GRANT forces RELEASE even if
//   dma_req=1; after the mandatory IDLE cycle the request is re-arbitrated (full RDY_LEAD again).
//   burst_cnt clears on leaving GRANT.
//  Undefined: no burst limit, burst_cnt logic absent; GRANT held as long as dma_req=1.
// TESTING
//  1 reset low mid-GRANT -> rdy=1, aec=1, grant=0, steal_cnt=0 immediately.
//  2 rdy_writes=0, req pulse held 5 cycles after grant -> rdy low 3 cycles before aec low;
//    grant for 5 cycles; 1 RELEASE; steal_cnt=5.
//  3 rdy_writes=1, cpu_rwn=1 on first HALT cycle -> grant on 2nd cycle after req; aec low same cycle.
//  4 req dropped in 2nd HALT cycle -> no grant, rdy=1 next cycle, steal_cnt unchanged.
//  5 FAIR_EN, MAX_BURST=4, req held 20 cycles -> grant bursts of 4 separated by RELEASE+IDLE+HALT.
//  6 steal_cnt at 16'hFFFE, 3 grant cycles -> holds 16'hFFFF; steal_clr with grant -> 0.

Source files
------------

// File: rtl/as65x_bus_arbiter_if.sv
// rtl/as65x_bus_arbiter_if.sv - CPU/DMA bus-sharing signals between the pad ring, cpu65 and the DMA requester
interface as65x_bus_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             cpu_rwn;
    logic             cpu_rdy_writes;
    logic             dma_req;
    logic             steal_clr;
    logic             dma_grant;
    logic             cpu_rdy;
    logic             cpu_aec;
    logic             arb_busy;
    logic [CNT_W-1:0] steal_cnt;

    modport master (
        output cpu_rwn, cpu_rdy_writes, dma_req, steal_clr,
        input  dma_grant, cpu_rdy, cpu_aec, arb_busy, steal_cnt
    );

    modport slave (
        input  cpu_rwn, cpu_rdy_writes, dma_req, steal_clr,
        output dma_grant, cpu_rdy, cpu_aec, arb_busy, steal_cnt
    );
endinterface

// File: rtl/as65x_bus_arbiter.sv
// rtl/as65x_bus_arbiter.sv - cycle-stealing as65x bus arbiter (RDY halt, AEC float, DMA grant)
// Optional burst limit enabled by defining AS65X_ARB_FAIR_EN.
module as65x_bus_arbiter #(
    parameter int RDY_LEAD  = 3,
    parameter int MAX_BURST = 40,
    parameter int CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_n,
    as65x_bus_arbiter_if.slave bus
);
    localparam int LEAD_W = $clog2(RDY_LEAD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HALT    = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LEAD_W-1:0] lead_cnt_q, lead_cnt_d;
    logic [CNT_W-1:0]  steal_cnt_q, steal_cnt_d;
    logic              rdy_q, rdy_d;
    logic              aec_q, aec_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              burst_limit;

    if (RDY_LEAD < 1 || MAX_BURST < 1) begin : g_param_check
        $error("as65x_bus_arbiter: RDY_LEAD and MAX_BURST must be >= 1");
    end

`ifdef AS65X_ARB_FAIR_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    assign burst_limit = (state_q == S_GRANT) && (burst_cnt_q == BURST_W'(MAX_BURST - 1));

    // Counts consecutive grant cycles; any exit from GRANT restarts the burst.
    always_comb begin
        burst_cnt_d = '0;
        if (state_q == S_GRANT && state_d == S_GRANT) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign burst_limit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lead_cnt_d = lead_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dma_req) begin
                    state_d    = S_HALT;
                    lead_cnt_d = '0;
                end
            end
            S_HALT: begin
                lead_cnt_d = lead_cnt_q + LEAD_W'(1);
                // A dropped request wins over both ways into GRANT.
                if (!bus.dma_req) begin
                    state_d = S_IDLE;
                end else if ((bus.cpu_rdy_writes && bus.cpu_rwn) ||
                             (lead_cnt_q == LEAD_W'(RDY_LEAD - 1))) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!bus.dma_req || burst_limit) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        rdy_d   = (state_d == S_IDLE);
        aec_d   = (state_d != S_GRANT);
        grant_d = (state_d == S_GRANT);
        busy_d  = (state_d != S_IDLE);
    end

    always_comb begin
        steal_cnt_d = steal_cnt_q;
        if (bus.steal_clr) begin
            steal_cnt_d = '0;
        end else if (state_q == S_GRANT && !(&steal_cnt_q)) begin
            steal_cnt_d = steal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lead_cnt_q  <= '0;
            steal_cnt_q <= '0;
            rdy_q       <= 1'b1;
            aec_q       <= 1'b1;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lead_cnt_q  <= lead_cnt_d;
            steal_cnt_q <= steal_cnt_d;
            rdy_q       <= rdy_d;
            aec_q       <= aec_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cpu_rdy   = rdy_q;
    assign bus.cpu_aec   = aec_q;
    assign bus.dma_grant = grant_q;
    assign bus.arb_busy  = busy_q;
    assign bus.steal_cnt = steal_cnt_q;

    a_no_grant_with_aec: assert property (@(posedge clk_i) disable iff (!rst_n)
        !(grant_q && aec_q));
    a_no_float_while_ready: assert property (@(posedge clk_i) disable iff (!rst_n)
        !(!aec_q && rdy_q));
endmodule

// File: tb/tb_as65x_bus_arbiter.sv
// tb/tb_as65x_bus_arbiter.sv - randomized self-checking bench for as65x_bus_arbiter
module tb_as65x_bus_arbiter;
    localparam int RDY_LEAD  = 3;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 8;
    localparam int CMAX      = (1 << CNT_W) - 1;
`ifdef AS65X_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    as65x_bus_arbiter_if #(.CNT_W(CNT_W)) bus ();

    as65x_bus_arbiter #(
        .RDY_LEAD (RDY_LEAD),
        .MAX_BURST(MAX_BURST),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    // One entry per bus cycle: expected outputs in that cycle and inputs applied during it.
    typedef struct {
        logic rdy, aec, grant, busy, req, rwn, clr;
    } ent_t;
    ent_t tr[$];

    function automatic ent_t mk(input logic rdy, aec, grant, busy, req, rwn, clr);
        ent_t e;
        e.rdy = rdy; e.aec = aec; e.grant = grant; e.busy = busy;
        e.req = req; e.rwn = rwn; e.clr = clr;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Timeline of one request episode: HALT lead-in, grant burst(s), RELEASE, IDLE.
    task automatic build(input bit rw, input int glen, input int abort_k,
                         input bit force_rwn1, input bit clr_last);
        int  rem;
        int  burst;
        bit  done;
        bit  first;
        bit  lastg;
        ent_t e;
        tr.delete();
        rem   = glen;
        done  = 1'b0;
        first = 1'b1;
        tr.push_back(mk(1, 1, 0, 0, 1, 1'($urandom_range(0, 1)), 0));
        while (!done) begin
            for (int k = 0; k < RDY_LEAD; k++) begin
                e = mk(0, 1, 0, 1, 1, (force_rwn1 && k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
                if (first && k == abort_k) begin
                    e.req = 1'b0;
                    tr.push_back(e);
                    tr.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                    done = 1'b1;
                    break;
                end
                tr.push_back(e);
                if ((rw && e.rwn) || k == RDY_LEAD - 1) break;
            end
            if (done) break;
            first = 1'b0;
            burst = (FAIR && rem > MAX_BURST) ? MAX_BURST : rem;
            for (int j = 0; j < burst; j++) begin
                lastg = (j == burst - 1) && (burst == rem);
                tr.push_back(mk(0, 0, 1, 1, !lastg, 1'($urandom_range(0, 1)), clr_last && lastg));
            end
            rem = rem - burst;
            tr.push_back(mk(0, 1, 0, 1, rem > 0, 1'($urandom_range(0, 1)), 0));
            tr.push_back(mk(1, 1, 0, 0, rem > 0, 1'($urandom_range(0, 1)), 0));
            if (rem == 0) done = 1'b1;
        end
        tr.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic play(input string tag, input bit rw);
        bus.cpu_rdy_writes = rw;
        for (int c = 0; c < tr.size(); c++) begin
            if (c > 0) step();
            total += 5;
            if (bus.cpu_rdy !== tr[c].rdy) begin
                bad++; $display("FAIL %s rdy cycle %0d got %b want %b", tag, c, bus.cpu_rdy, tr[c].rdy);
            end
            if (bus.cpu_aec !== tr[c].aec) begin
                bad++; $display("FAIL %s aec cycle %0d got %b want %b", tag, c, bus.cpu_aec, tr[c].aec);
            end
            if (bus.dma_grant !== tr[c].grant) begin
                bad++; $display("FAIL %s grant cycle %0d got %b want %b", tag, c, bus.dma_grant, tr[c].grant);
            end
            if (bus.arb_busy !== tr[c].busy) begin
                bad++; $display("FAIL %s busy cycle %0d got %b want %b", tag, c, bus.arb_busy, tr[c].busy);
            end
            if (bus.steal_cnt !== CNT_W'(exp_cnt)) begin
                bad++; $display("FAIL %s steal_cnt cycle %0d got %0d want %0d", tag, c, bus.steal_cnt, exp_cnt);
            end
            bus.dma_req   = tr[c].req;
            bus.cpu_rwn   = tr[c].rwn;
            bus.steal_clr = tr[c].clr;
            if (tr[c].clr) exp_cnt = 0;
            else if (tr[c].grant && exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
        end
        step();
        bus.steal_clr = 1'b0;
        total++;
        if (bus.steal_cnt !== CNT_W'(exp_cnt)) begin
            bad++; $display("FAIL %s final steal_cnt got %0d want %0d", tag, bus.steal_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        total += 5;
        if (bus.cpu_rdy !== 1'b1)   begin bad++; $display("FAIL reset rdy got %b want 1", bus.cpu_rdy); end
        if (bus.cpu_aec !== 1'b1)   begin bad++; $display("FAIL reset aec got %b want 1", bus.cpu_aec); end
        if (bus.dma_grant !== 1'b0) begin bad++; $display("FAIL reset grant got %b want 0", bus.dma_grant); end
        if (bus.arb_busy !== 1'b0)  begin bad++; $display("FAIL reset busy got %b want 0", bus.arb_busy); end
        if (bus.steal_cnt !== '0)   begin bad++; $display("FAIL reset steal_cnt got %0d want 0", bus.steal_cnt); end
        @(negedge clk_i);
        rst_n = 1'b1;
        step();
        exp_cnt = 0;
    endtask

    task automatic test_worst_latency();
        build(1'b0, 5, -1, 1'b0, 1'b0);
        play("worst_latency", 1'b0);
    endtask

    task automatic test_early_exit();
        build(1'b1, 3, -1, 1'b1, 1'b0);
        play("early_exit", 1'b1);
    endtask

    task automatic test_abort();
        build(1'b0, 4, 1, 1'b0, 1'b0);
        play("abort", 1'b0);
    endtask

    task automatic test_long_hold();
        build(1'b0, 20, -1, 1'b0, 1'b0);
        play("long_hold", 1'b0);
    endtask

    task automatic test_random();
        bit rw;
        int glen;
        int ab;
        for (int n = 0; n < 30; n++) begin
            rw   = 1'($urandom_range(0, 1));
            glen = $urandom_range(1, 12);
            ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, RDY_LEAD - 1) : -1;
            build(rw, glen, ab, 1'b0, 1'b0);
            play("random", rw);
        end
    endtask

    task automatic test_saturation();
        bus.steal_clr = 1'b1;
        step();
        bus.steal_clr = 1'b0;
        exp_cnt = 0;
        total++;
        if (bus.steal_cnt !== '0) begin
            bad++; $display("FAIL sat_clear got %0d want 0", bus.steal_cnt);
        end
        build(1'b0, CMAX - 1, -1, 1'b0, 1'b0);
        play("sat_fill", 1'b0);
        build(1'b1, 3, -1, 1'b0, 1'b0);
        play("sat_hold", 1'b1);
        total++;
        if (bus.steal_cnt !== CNT_W'(CMAX)) begin
            bad++; $display("FAIL sat_top got %0d want %0d", bus.steal_cnt, CMAX);
        end
        build(1'b0, 1, -1, 1'b0, 1'b1);
        play("clr_with_grant", 1'b0);
        total++;
        if (bus.steal_cnt !== '0) begin
            bad++; $display("FAIL clr_with_grant got %0d want 0", bus.steal_cnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        bus.cpu_rdy_writes = 1'b0;
        bus.dma_req        = 1'b1;
        repeat (RDY_LEAD + 3) step();
        total += 2;
        if (bus.dma_grant !== 1'b1) begin
            bad++; $display("FAIL mid_grant pre grant got %b want 1", bus.dma_grant);
        end
        if (bus.steal_cnt !== CNT_W'(exp_cnt + 2)) begin
            bad++; $display("FAIL mid_grant pre steal_cnt got %0d want %0d", bus.steal_cnt, exp_cnt + 2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.cpu_rdy !== 1'b1)   begin bad++; $display("FAIL mid_grant rdy got %b want 1", bus.cpu_rdy); end
        if (bus.cpu_aec !== 1'b1)   begin bad++; $display("FAIL mid_grant aec got %b want 1", bus.cpu_aec); end
        if (bus.dma_grant !== 1'b0) begin bad++; $display("FAIL mid_grant grant got %b want 0", bus.dma_grant); end
        if (bus.steal_cnt !== '0)   begin bad++; $display("FAIL mid_grant steal_cnt got %0d want 0", bus.steal_cnt); end
        bus.dma_req = 1'b0;
        exp_cnt = 0;
        @(negedge clk_i);
        rst_n = 1'b1;
        step();
        total++;
        if (bus.arb_busy !== 1'b0) begin
            bad++; $display("FAIL mid_grant post busy got %b want 0", bus.arb_busy);
        end
    endtask

    initial begin
        bus.cpu_rwn        = 1'b1;
        bus.cpu_rdy_writes = 1'b0;
        bus.dma_req        = 1'b0;
        bus.steal_clr      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_worst_latency();
        test_early_exit();
        test_abort();
        test_long_hold();
        test_random();
        test_saturation();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
